regfile: RTL and testbench



---
 rtl/polaris_pkg.sv | 11 +
 rtl/regfile_ram.sv | 28 ++
 rtl/regfile.sv | 91 +++++++++
 tb/tb_regfile.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/polaris_pkg.sv
// Shared Polaris core constants: register-file geometry defaults and the
// clear-sequencer state encoding.
package polaris_pkg;

  localparam int XLEN_DEF = 64;
  localparam int AW_DEF   = 5;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

endpackage

// File: rtl/regfile_ram.sv
// Register storage: one write port, two asynchronous-address read ports.
// Kept free of reset so it can be swapped for a vendor RAM macro.
module regfile_ram
  import polaris_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic            clk_i,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdat,
  input  logic [AW-1:0]   raddr_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [XLEN-1:0] rdat_a,
  output logic [XLEN-1:0] rdat_b
);

  logic [XLEN-1:0] mem [2**AW];

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdat;
  end

  assign rdat_a = mem[raddr_a];
  assign rdat_b = mem[raddr_b];

endmodule

// File: rtl/regfile.sv
// RV64I integer register file: 2R/1W, registered reads with write-first
// bypass, x0 hardwired to zero, and a post-reset clear sequencer.
module regfile
  import polaris_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [AW-1:0]   rs1_i,
  input  logic [AW-1:0]   rs2_i,
  output logic [XLEN-1:0] rs1_dat_o,
  output logic [XLEN-1:0] rs2_dat_o,
  input  logic [AW-1:0]   rd_i,
  input  logic            rd_we_i,
  input  logic [XLEN-1:0] rd_dat_i,
  output logic            busy_o
);

  localparam logic [AW-1:0] CTR_LAST = {AW{1'b1}};

  logic [0:0]    state;
  logic [AW-1:0] ctr;
  logic          clearing;

  logic            ram_we;
  logic [AW-1:0]   ram_waddr;
  logic [XLEN-1:0] ram_wdat;

  logic [1:0][AW-1:0]   rs_addr;
  logic [1:0][XLEN-1:0] rs_mem;
  logic [1:0][XLEN-1:0] rs_nxt;
  logic [1:0][XLEN-1:0] rs_q;

  assign clearing = (state == ST_CLEAR);
  assign rs_addr  = {rs2_i, rs1_i};

  // Reset must leave the array untouched, so every write is gated by reset_i.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = rd_i;
    ram_wdat  = rd_dat_i;
    if (!reset_i) begin
      if (clearing) begin
        ram_we    = 1'b1;
        ram_waddr = ctr;
        ram_wdat  = '0;
      end else begin
        ram_we = rd_we_i && (rd_i != '0);
      end
    end
  end

  regfile_ram #(.XLEN(XLEN), .AW(AW)) u_ram (
    .clk_i   (clk_i),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdat    (ram_wdat),
    .raddr_a (rs_addr[0]),
    .raddr_b (rs_addr[1]),
    .rdat_a  (rs_mem[0]),
    .rdat_b  (rs_mem[1])
  );

  // Per-port select: x0/clear force zero, then same-edge writeback, then array.
  for (genvar p = 0; p < 2; p++) begin : g_port
    assign rs_nxt[p] = (clearing || rs_addr[p] == '0)         ? '0       :
                       (rd_we_i && rd_i == rs_addr[p])         ? rd_dat_i :
                                                                 rs_mem[p];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= ST_CLEAR;
      ctr   <= {{(AW-1){1'b0}}, 1'b1};
      rs_q  <= '0;
    end else begin
      rs_q <= rs_nxt;
      if (clearing) begin
        ctr <= ctr + 1'b1;
        if (ctr == CTR_LAST) state <= ST_READY;
      end
    end
  end

  assign rs1_dat_o = rs_q[0];
  assign rs2_dat_o = rs_q[1];
  assign busy_o    = clearing;

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: the driver queues expected outputs per edge,
// the monitor pops and compares them just after that edge.
module tb_regfile;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [4:0]  rs1_i = '0, rs2_i = '0, rd_i = '0;
  logic        rd_we_i = 1'b0;
  logic [63:0] rd_dat_i = '0;
  logic [63:0] rs1_dat_o, rs2_dat_o;
  logic        busy_o;

  typedef struct {
    logic [63:0] e1;
    logic [63:0] e2;
    logic        eb;
    string       nm;
  } exp_t;

  exp_t sb[$];
  bit   issue = 1'b0;
  bit   mon_c;
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  regfile dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .rs1_i     (rs1_i),
    .rs2_i     (rs2_i),
    .rs1_dat_o (rs1_dat_o),
    .rs2_dat_o (rs2_dat_o),
    .rd_i      (rd_i),
    .rd_we_i   (rd_we_i),
    .rd_dat_i  (rd_dat_i),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Monitor: compare one queued expectation per checked edge.
  always @(posedge clk_i) begin
    mon_c = issue;
    #1;
    if (mon_c) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: output present with no expectation queued");
      end else begin
        mon_e = sb.pop_front();
        if (rs1_dat_o !== mon_e.e1 || rs2_dat_o !== mon_e.e2 || busy_o !== mon_e.eb) begin
          errors++;
          $display("FAIL %s: got rs1=%h rs2=%h busy=%b expected rs1=%h rs2=%h busy=%b",
                   mon_e.nm, rs1_dat_o, rs2_dat_o, busy_o, mon_e.e1, mon_e.e2, mon_e.eb);
        end
      end
    end
  end

  task automatic step(input logic rst, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [4:0] rd, input logic we, input logic [63:0] d,
                      input bit chk, input logic [63:0] e1, input logic [63:0] e2,
                      input logic eb, input string nm);
    exp_t e;
    @(negedge clk_i);
    reset_i  = rst;
    rs1_i    = a1;
    rs2_i    = a2;
    rd_i     = rd;
    rd_we_i  = we;
    rd_dat_i = d;
    issue    = chk;
    if (chk) begin
      e.e1 = e1; e.e2 = e2; e.eb = eb; e.nm = nm;
      sb.push_back(e);
    end
  endtask

  // n clear edges; busy drops after the last one only when last_ready is set.
  task automatic clear_edges(input int n, input bit last_ready, input string nm);
    for (int i = 1; i <= n; i++)
      step(1'b0, 5'(i), 5'(31 - i), 5'd0, 1'b0, '0, 1'b1, '0, '0,
           (last_ready && i == n) ? 1'b0 : 1'b1, nm);
  endtask

  initial begin
    // Reset held for two edges.
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, '0, 1'b1, '0, '0, 1'b1, "reset");
    step(1'b1, 5'd3, 5'd4, 5'd0, 1'b0, '0, 1'b1, '0, '0, 1'b1, "reset");

    // Clear: 31 edges, with an ignored write to x9 on the ctr=10 edge.
    clear_edges(9, 1'b0, "clear");
    step(1'b0, 5'd9, 5'd9, 5'd9, 1'b1, 64'h55, 1'b1, '0, '0, 1'b1, "clear_wr9");
    clear_edges(21, 1'b1, "clear_tail");

    // First ready cycle: write x5.
    step(1'b0, 5'd9, 5'd1, 5'd5, 1'b1, 64'hDEADBEEF_CAFEF00D, 1'b1, '0, '0, 1'b0, "wr_x5");
    step(1'b0, 5'd5, 5'd9, 5'd0, 1'b0, '0, 1'b1, 64'hDEADBEEF_CAFEF00D, '0, 1'b0, "rd_x5_x9");
    for (int r = 0; r < 32; r++)
      step(1'b0, 5'(r), 5'(r), 5'd0, 1'b0, '0, 1'b1,
           (r == 5) ? 64'hDEADBEEF_CAFEF00D : 64'h0,
           (r == 5) ? 64'hDEADBEEF_CAFEF00D : 64'h0, 1'b0, "rd_all");

    // x0 stays zero, including through the bypass path.
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, '0, '0, 1'b0, "wr_x0");
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, '0, 1'b1, '0, '0, 1'b0, "rd_x0");

    // Write-first bypass on both ports, then plain reads.
    step(1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 64'h1234, 1'b1, 64'h1234, 64'h1234, 1'b0, "bypass_x7");
    step(1'b0, 5'd7, 5'd7, 5'd0, 1'b0, '0, 1'b1, 64'h1234, 64'h1234, 1'b0, "rd_x7");

    // Fill x1..x31 with their index, then a concurrent pair read.
    for (int r = 1; r < 32; r++)
      step(1'b0, 5'd0, 5'd0, 5'(r), 1'b1, 64'(r), 1'b1, '0, '0, 1'b0, "fill");
    step(1'b0, 5'd3, 5'd31, 5'd0, 1'b0, '0, 1'b1, 64'd3, 64'd31, 1'b0, "pair_3_31");

    // Reset in READY with a write presented; then reset again mid-clear at ctr=20.
    step(1'b1, 5'd3, 5'd31, 5'd3, 1'b1, 64'hAA, 1'b1, '0, '0, 1'b1, "reset_ready");
    clear_edges(19, 1'b0, "clear_part");
    step(1'b1, 5'd3, 5'd31, 5'd0, 1'b0, '0, 1'b1, '0, '0, 1'b1, "reset_mid");
    clear_edges(31, 1'b1, "clear_restart");

    // Everything zero after the clear.
    for (int r = 0; r < 32; r++)
      step(1'b0, 5'(r), 5'(31 - r), 5'd0, 1'b0, '0, 1'b1, '0, '0, 1'b0, "rd_cleared");

    // Rewrite and read back, mixing bypass on one port with array on the other.
    step(1'b0, 5'd0, 5'd0, 5'd31, 1'b1, 64'd31, 1'b1, '0, '0, 1'b0, "wr_x31");
    step(1'b0, 5'd3, 5'd31, 5'd3, 1'b1, 64'd3, 1'b1, 64'd3, 64'd31, 1'b0, "pair_bypass");
    step(1'b0, 5'd3, 5'd31, 5'd0, 1'b0, '0, 1'b1, 64'd3, 64'd31, 1'b0, "pair_mem");

    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, '0, 1'b0, '0, '0, 1'b0, "idle");
    @(negedge clk_i);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
